// File: rtl/tc_pkg.sv
// tc_pkg: shared state encoding, defaults and config record for the burst interrupter
package tc_pkg;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_MIN_OFF = 4;
  typedef enum logic [1:0] {IDLE, ON, OFF, FAULT} state_t;
  typedef struct packed {
    logic [DEF_CNT_W-1:0] period;
    logic [DEF_CNT_W-1:0] eff_on;
  } cfg_t;
endpackage

// File: rtl/tc_cfg_shadow.sv
// tc_cfg_shadow: load validation, on-time clamp, cfg_err and active/pending config registers
module tc_cfg_shadow
  import tc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on_time,
  input  logic             direct,
  input  logic             apply,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_eff_on,
  output logic [CNT_W-1:0] sel_eff_on,
  output logic             act_valid,
  output logic             cfg_err
);
  localparam logic [CNT_W-1:0] MO = CNT_W'(MIN_OFF);
  logic [CNT_W-1:0] act_per_q, act_per_d, act_on_q, act_on_d;
  logic [CNT_W-1:0] pend_per_q, pend_per_d, pend_on_q, pend_on_d;
  logic [CNT_W-1:0] room, eff;
  logic pend_q, pend_d, err_q, err_d, ok;
  always_comb begin
    room = period - MO;
    eff = on_time < room ? on_time : room;
    ok = load && period > MO && on_time != '0;
    err_d = load && !ok;
    act_per_d = act_per_q;
    act_on_d = act_on_q;
    pend_per_d = pend_per_q;
    pend_on_d = pend_on_q;
    pend_d = pend_q;
    if (apply && pend_q) begin
      act_per_d = pend_per_q;
      act_on_d = pend_on_q;
      pend_d = 1'b0;
    end
    if (ok && direct) begin
      act_per_d = period;
      act_on_d = eff;
      pend_d = 1'b0;
    end else if (ok) begin
      pend_per_d = period;
      pend_on_d = eff;
      pend_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      act_per_q <= '0;
      act_on_q <= '0;
      pend_per_q <= '0;
      pend_on_q <= '0;
      pend_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      act_per_q <= act_per_d;
      act_on_q <= act_on_d;
      pend_per_q <= pend_per_d;
      pend_on_q <= pend_on_d;
      pend_q <= pend_d;
      err_q <= err_d;
    end
  end
  assign act_period = act_per_q;
  assign act_eff_on = act_on_q;
  assign act_valid = act_per_q != '0;
  assign sel_eff_on = pend_q ? pend_on_q : act_on_q;
  assign cfg_err = err_q;
endmodule

// File: rtl/tc_interrupter.sv
// tc_interrupter: burst gate-enable generator with programmable period/on-time, minimum off-time and latched fault
module tc_interrupter
  import tc_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] on_time,
  input  logic             load,
  input  logic             fault,
  input  logic             clear_fault,
  output logic             gate_en,
  output logic             pulse_start,
  output logic             busy,
  output logic             fault_latched,
  output logic             cfg_err
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, act_period, act_eff_on, sel_eff_on;
  logic act_valid, direct, apply, gate_q, start_q, busy_q, flt_q;
  tc_cfg_shadow #(.CNT_W(CNT_W), .MIN_OFF(MIN_OFF)) u_cfg (
    .clk(clk),
    .reset(reset),
    .load(load),
    .period(period),
    .on_time(on_time),
    .direct(direct),
    .apply(apply),
    .act_period(act_period),
    .act_eff_on(act_eff_on),
    .sel_eff_on(sel_eff_on),
    .act_valid(act_valid),
    .cfg_err(cfg_err)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (enable && act_valid) begin
        state_d = ON;
        cnt_d = act_eff_on - 1'b1;
      end
      ON: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = OFF;
          cnt_d = act_period - act_eff_on - 1'b1;
        end else if (!enable) begin
          state_d = OFF;
          cnt_d = CNT_W'(MIN_OFF - 1);
        end
      end
      OFF: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = enable ? ON : IDLE;
          cnt_d = enable ? sel_eff_on - 1'b1 : '0;
        end
      end
      FAULT: if (clear_fault) begin
        state_d = IDLE;
        cnt_d = '0;
      end
    endcase
    if (fault) begin
      state_d = FAULT;
      cnt_d = '0;
    end
    direct = state_q == FAULT || (state_q == IDLE && !(enable && act_valid));
    apply = (state_q == OFF && state_d == ON) || (state_q != IDLE && state_d == IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gate_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      flt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gate_q <= state_d == ON;
      start_q <= state_d == ON && state_q != ON;
      busy_q <= state_d == ON || state_d == OFF;
      flt_q <= state_d == FAULT;
    end
  end
  assign gate_en = gate_q;
  assign pulse_start = start_q;
  assign busy = busy_q;
  assign fault_latched = flt_q;
endmodule

// File: tb/tb_tc_interrupter.sv
// tb_tc_interrupter: randomized and directed checks of tc_interrupter against a window-position reference model
module tb_tc_interrupter;
  localparam int MIN_OFF = 4;
  logic clk, reset, enable, load, fault, clear_fault;
  logic [15:0] period, on_time;
  logic gate_en, pulse_start, busy, fault_latched, cfg_err;
  logic [4:0] obs;
  int checks, errors;
  bit m_run, m_flt, m_ps, m_err, p_flag;
  int m_pos, m_on, m_win, a_per, a_on, p_per, p_on;

  tc_interrupter #(.CNT_W(16), .MIN_OFF(MIN_OFF)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .period(period),
    .on_time(on_time),
    .load(load),
    .fault(fault),
    .clear_fault(clear_fault),
    .gate_en(gate_en),
    .pulse_start(pulse_start),
    .busy(busy),
    .fault_latched(fault_latched),
    .cfg_err(cfg_err)
  );

  assign obs = {gate_en, pulse_start, busy, fault_latched, cfg_err};
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] exp5();
    return {m_run && m_pos < m_on, m_ps, m_run, m_flt, m_err};
  endfunction

  task automatic model_edge();
    int pr, ot, eff;
    bit ok, idle, direct;
    pr = int'(period);
    ot = int'(on_time);
    ok = load && pr > MIN_OFF && ot != 0;
    eff = ot < pr - MIN_OFF ? ot : pr - MIN_OFF;
    if (reset) begin
      {m_run, m_flt, m_ps, m_err, p_flag} = '0;
      m_pos = 0; m_on = 0; m_win = 0; a_per = 0; a_on = 0; p_per = 0; p_on = 0;
      return;
    end
    m_err = load && !ok;
    m_ps = 0;
    idle = !m_run && !m_flt;
    direct = m_flt || (idle && !(enable && a_per != 0));
    if (fault) begin
      m_flt = 1;
      m_run = 0;
    end else if (m_flt) begin
      if (clear_fault) begin
        m_flt = 0;
        if (p_flag) begin a_per = p_per; a_on = p_on; p_flag = 0; end
      end
    end else if (idle) begin
      if (enable && a_per != 0) begin
        m_run = 1; m_pos = 0; m_on = a_on; m_win = a_per; m_ps = 1;
      end
    end else if (m_pos == m_win - 1) begin
      if (p_flag) begin a_per = p_per; a_on = p_on; p_flag = 0; end
      if (enable) begin
        m_pos = 0; m_on = a_on; m_win = a_per; m_ps = 1;
      end else m_run = 0;
    end else begin
      if (!enable && m_pos < m_on - 1) begin
        m_on = m_pos + 1;
        m_win = m_pos + 1 + MIN_OFF;
      end
      m_pos++;
    end
    if (ok) begin
      if (direct) begin a_per = pr; a_on = eff; p_flag = 0; end
      else begin p_per = pr; p_on = eff; p_flag = 1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; load = 0; fault = 0; clear_fault = 0; period = 0; on_time = 0;
    step(); step();
    if (obs !== 5'b0) begin errors++; $display("FAIL reset outputs: got %b want 00000", obs); end
    checks++;
    reset = 0;
    step();
    if (obs !== exp5()) begin errors++; $display("FAIL reset idle: got %b want %b", obs, exp5()); end
    checks++;
  endtask

  task automatic test_basic();
    int last, highs;
    load = 1; period = 10; on_time = 3;
    step();
    if (obs !== exp5()) begin errors++; $display("FAIL basic load: got %b want %b", obs, exp5()); end
    checks++;
    load = 0; enable = 1; last = -1; highs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL basic cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
      if (i >= 30) highs += int'(gate_en);
      if (pulse_start) begin
        if (last >= 0) begin
          if (i - last != 10) begin errors++; $display("FAIL basic spacing: got %0d want 10", i - last); end
          checks++;
        end
        last = i;
      end
    end
    if (highs != 3) begin errors++; $display("FAIL basic high time: got %0d want 3", highs); end
    checks++;
  endtask

  task automatic test_clamp();
    int highs;
    load = 1; period = 10; on_time = 9;
    step();
    load = 0; highs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL clamp cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
      if (i >= 30) highs += int'(gate_en);
    end
    if (highs != 6) begin errors++; $display("FAIL clamp high time: got %0d want 6", highs); end
    checks++;
  endtask

  task automatic test_reject();
    int highs;
    load = 1; period = 4; on_time = 2;
    step();
    load = 0;
    if (cfg_err !== 1'b1) begin errors++; $display("FAIL reject cfg_err: got %b want 1", cfg_err); end
    checks++;
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL reject cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
      if (i >= 20) highs += int'(gate_en);
    end
    if (highs != 6) begin errors++; $display("FAIL reject high time: got %0d want 6", highs); end
    checks++;
  endtask

  task automatic test_reconfig();
    int n, highs;
    n = 0;
    while (!pulse_start && n < 30) begin step(); n++; end
    n = 0;
    while (gate_en && n < 30) begin step(); n++; end
    if (gate_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL reconfig reach OFF: got %b want gate 0 busy 1", obs); end
    checks++;
    step();
    load = 1; period = 20; on_time = 5;
    step();
    load = 0; highs = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL reconfig cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
      if (i >= 40) highs += int'(gate_en);
    end
    if (highs != 5) begin errors++; $display("FAIL reconfig high time: got %0d want 5", highs); end
    checks++;
  endtask

  task automatic test_enable_drop();
    int n, bcnt;
    n = 0;
    while (!pulse_start && n < 40) begin step(); n++; end
    if (pulse_start !== 1'b1) begin errors++; $display("FAIL drop wait pulse: got %b want 1", pulse_start); end
    checks++;
    step();
    enable = 0;
    step();
    if (gate_en !== 1'b0) begin errors++; $display("FAIL drop gate: got %b want 0", gate_en); end
    checks++;
    bcnt = int'(busy);
    for (int i = 0; i < 7; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL drop cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
      bcnt += int'(busy);
    end
    if (bcnt != 4) begin errors++; $display("FAIL drop busy cycles: got %0d want 4", bcnt); end
    checks++;
  endtask

  task automatic test_fault();
    int n;
    enable = 1; n = 0;
    while (!gate_en && n < 40) begin step(); n++; end
    fault = 1;
    step();
    fault = 0;
    if (gate_en !== 1'b0 || fault_latched !== 1'b1) begin errors++; $display("FAIL fault entry: got %b want gate 0 latched 1", obs); end
    checks++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL fault hold %0d: got %b want %b", i, obs, exp5()); end
      checks++;
    end
    clear_fault = 1; fault = 1;
    step();
    if (fault_latched !== 1'b1) begin errors++; $display("FAIL fault beats clear: got %b want 1", fault_latched); end
    checks++;
    fault = 0;
    step();
    clear_fault = 0;
    if (obs !== 5'b0) begin errors++; $display("FAIL fault clear: got %b want 00000", obs); end
    checks++;
    step();
    if (pulse_start !== 1'b1 || obs !== exp5()) begin errors++; $display("FAIL fault restart: got %b want %b", obs, exp5()); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n;
    load = 1; period = 10; on_time = 3;
    step();
    load = 0;
    for (int i = 0; i < 30; i++) step();
    n = 0;
    while (!pulse_start && n < 30) begin step(); n++; end
    step();
    reset = 1;
    step();
    reset = 0;
    if (obs !== 5'b0) begin errors++; $display("FAIL reset mid: got %b want 00000", obs); end
    checks++;
    for (int i = 0; i < 15; i++) begin
      step();
      if (obs !== exp5() || busy !== 1'b0) begin errors++; $display("FAIL reset invalid cfg %0d: got %b want %b", i, obs, exp5()); end
      checks++;
    end
    load = 1;
    step();
    load = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL reset reload %0d: got %b want %b", i, obs, exp5()); end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 499) == 0;
      load = $urandom_range(0, 9) == 0;
      period = 16'($urandom_range(0, 24));
      on_time = $urandom_range(0, 7) == 0 ? 16'hFFFF : 16'($urandom_range(0, 24));
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      fault = $urandom_range(0, 99) == 0;
      clear_fault = $urandom_range(0, 19) == 0;
      step();
      if (obs !== exp5()) begin errors++; $display("FAIL random cyc %0d: got %b want %b", i, obs, exp5()); end
      checks++;
    end
    {reset, load, fault, clear_fault} = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_clamp();
    test_reject();
    test_reconfig();
    test_enable_drop();
    test_fault();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tc_interrupter.md
Name: tc_interrupter

Overview:
Burst interrupter for the coil bridge driver, clocked by the divide-by-8 clock output. It generates a repeating gate-enable window with programmable period and on-time. A hard minimum off-time is always enforced. A latched fault path forces the gate off within one cycle. gate_en feeds the bridge drive logic directly downstream.

Parameters:
CNT_W, 16, width of the period, on-time and internal counters
MIN_OFF, 4, minimum gate-off cycles per period and after enable drop; must be >=1 and <2**CNT_W

Ports:
clk  input  1  divided system clock (divide-by-8 clock output)
reset  input  1  synchronous, active-high reset
enable  input  1  run request, level
period  input  CNT_W  requested period in clk cycles
on_time  input  CNT_W  requested gate-on cycles
load  input  1  one-cycle strobe; captures period/on_time
fault  input  1  synchronous fault level from protection logic
clear_fault  input  1  one-cycle strobe; releases the latched fault
gate_en  output  1  registered bridge enable
pulse_start  output  1  one-cycle strobe in the first ON cycle of each pulse
busy  output  1  high in ON or OFF
fault_latched  output  1  high in FAULT
cfg_err  output  1  one-cycle strobe on a rejected load

Behaviour:
- Reset values: all outputs 0, state IDLE, counter 0, active and pending config 0 (invalid), pending flag 0.
- Reset mid-operation: gate_en is 0 on the cycle after reset is sampled; the state returns to IDLE.
- Load validation: a load is accepted only if period > MIN_OFF and on_time != 0. Otherwise cfg_err pulses in the next cycle and no configuration changes.
- eff_on = min(on_time, period - MIN_OFF), computed at load time with no overflow at CNT_W. This guarantees off-time >= MIN_OFF.
- Accepted load in IDLE or FAULT: written to the active registers directly.
- Accepted load in ON or OFF: written to the pending registers, and the pending flag is set. A second load overwrites the pending value. Pending is applied at the OFF->ON boundary, and also when the block returns to IDLE.
- States: IDLE, ON, OFF, FAULT. gate_en = (state==ON), registered. busy = ON|OFF. fault_latched = FAULT.
- IDLE: if enable and the active config is valid, go to ON next cycle with cnt = eff_on-1 and pulse_start=1.
- ON: each cycle cnt decrements.
  - When cnt==0: go to OFF with cnt = period-eff_on-1.
  - If enable is low in ON: go to OFF next cycle with cnt = MIN_OFF-1. This truncates the pulse but still enforces the minimum off-time.
- OFF: when cnt==0:
  - if enable is high, apply pending if set, then go to ON with pulse_start=1;
  - otherwise go to IDLE.
  - enable dropping during OFF does not shorten OFF.
- FAULT: entered from any state the cycle after fault=1; gate_en=0 that same cycle.
  - Exit to IDLE only on clear_fault with fault=0 in the same cycle.
  - fault beats clear_fault. fault beats load-induced transitions.
- Period identity: in steady state, rising edges of gate_en are exactly period cycles apart, with high time exactly eff_on.
- Simultaneous events:
  - load and an ON entry in the same cycle: the pulse uses the old config; the new one waits as pending.
  - reset beats everything.

Decomposition:
- Package tc_pkg:
  - state enum (IDLE, ON, OFF, FAULT)
  - default MIN_OFF constant
  - a config struct {period, eff_on} sized by CNT_W.
- One sub-module, tc_cfg_shadow: load validation, clamp, cfg_err, active/pending registers, pending apply.
- The FSM and counter stay in tc_interrupter.

Test Plan:
- Basic run: MIN_OFF=4; load period=10, on_time=3; assert enable -> gate_en high 3 / low 7 repeating; pulse_start every 10 cycles; busy=1.
- Clamp: load period=10, on_time=9 -> gate_en high 6 / low 4. Reject: load period=4, on_time=2 -> cfg_err one cycle, timing unchanged.
- Reconfigure: load period=20, on_time=5 in the middle of OFF -> the current period completes at 10 cycles; the next pulse is 5 high / 15 low.
- Enable drop: deassert enable in cycle 2 of ON -> gate_en low the next cycle; busy stays high for exactly 4 more cycles, then IDLE.
- Fault: fault=1 for one cycle during ON -> gate_en=0 and fault_latched=1 the next cycle. clear_fault with fault=1 -> stays in FAULT. clear_fault with fault=0 -> IDLE, then restarts if enable is high.
- Reset mid-ON with period=10, on_time=3 -> all outputs 0 the next cycle; no pulse until a new valid load, since the config resets to invalid.
